// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Purpose  : Round-robin arbiter between the I-cache (port 0) and the
//             D-cache (port 1) for the single 128-bit main-memory block port.
//             Each granted request runs as a fixed-latency memory access of
//             MEM_LAT cycles, followed by a one-cycle ack to the winner.
//  Options  : WRBUF_EN - adds a one-entry posted write buffer that acks
//             writes immediately and drains to memory when the bus is idle.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_W  = 10,
    parameter int BLK_W   = 128,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [BLK_W-1:0]  wdata0,
    input  logic [BLK_W-1:0]  wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [BLK_W-1:0]  rdata0,
    output logic [BLK_W-1:0]  rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
    input  logic [BLK_W-1:0]  mem_rdata,
    output logic              busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;
`ifdef WRBUF_EN
    localparam logic [1:0] c_st_drain  = 2'd3;
`endif

    // Counter is loaded with MEM_LAT-1 so that the access phase spans MEM_LAT cycles
    localparam logic [3:0]        c_lat_m1   = 4'(MEM_LAT - 1);
    // Clears the 16-byte block offset
    localparam logic [ADDR_W-1:0] c_blk_mask = {{(ADDR_W-4){1'b1}}, 4'b0000};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [3:0]        r_cnt;
    logic              r_gnt;
    logic              r_rr;

    logic              w_any_req;
    logic              w_sel;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [BLK_W-1:0]  w_sel_wdata;
    logic              w_go_access;

`ifdef WRBUF_EN
    logic              r_buf_valid;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [BLK_W-1:0]  r_buf_data;
    logic              w_buf_hit;
    logic              w_go_post;
    logic              w_go_drain;
`endif

    // Pick the candidate port: round-robin pointer only matters when both request
    always_comb begin
        w_any_req = req0 | req1;
        if (req0 && req1) begin
            w_sel = r_rr;
        end else begin
            w_sel = req1 & ~req0;
        end
        w_sel_we    = w_sel ? we1    : we0;
        w_sel_addr  = w_sel ? addr1  : addr0;
        w_sel_wdata = w_sel ? wdata1 : wdata0;
`ifdef WRBUF_EN
        // A read of the block sitting in the buffer must see the posted data
        w_buf_hit   = r_buf_valid && ((w_sel_addr & c_blk_mask) == r_buf_addr);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decision
    always_comb begin
        w_state_nxt = r_state;
        w_go_access = 1'b0;
`ifdef WRBUF_EN
        w_go_post   = 1'b0;
        w_go_drain  = 1'b0;
`endif
        case (r_state)
            c_st_idle: begin
`ifdef WRBUF_EN
                if (w_any_req) begin
                    if (w_sel_we) begin
                        // Buffer full: empty it first, then re-arbitrate
                        if (!r_buf_valid) begin
                            w_go_post = 1'b1;
                        end else begin
                            w_go_drain = 1'b1;
                        end
                    end else if (w_buf_hit) begin
                        w_go_drain = 1'b1;
                    end else begin
                        w_go_access = 1'b1;
                    end
                end else if (r_buf_valid) begin
                    w_go_drain = 1'b1;
                end
                if (w_go_post) begin
                    w_state_nxt = c_st_resp;
                end else if (w_go_drain) begin
                    w_state_nxt = c_st_drain;
                end else if (w_go_access) begin
                    w_state_nxt = c_st_access;
                end
`else
                if (w_any_req) begin
                    w_go_access = 1'b1;
                    w_state_nxt = c_st_access;
                end
`endif
            end
            c_st_access: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
`ifdef WRBUF_EN
            c_st_drain: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = c_st_idle;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // State-decoded outputs; async reset drops them the moment rst_n falls
    always_comb begin
        ack0   = (r_state == c_st_resp) && !r_gnt;
        ack1   = (r_state == c_st_resp) &&  r_gnt;
`ifdef WRBUF_EN
        mem_en = (r_state == c_st_access) || (r_state == c_st_drain);
        busy   = (r_state != c_st_idle) || r_buf_valid;
`else
        mem_en = (r_state == c_st_access);
        busy   = (r_state != c_st_idle);
`endif
    end

    // Grant bookkeeping, memory command registers, latency counter and read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 4'd0;
            r_gnt       <= 1'b0;
            r_rr        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata0      <= '0;
            rdata1      <= '0;
`ifdef WRBUF_EN
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_data  <= '0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_go_access) begin
                        r_gnt     <= w_sel;
                        r_rr      <= ~w_sel;
                        mem_we    <= w_sel_we;
                        mem_addr  <= w_sel_addr & c_blk_mask;
                        mem_wdata <= w_sel_wdata;
                        r_cnt     <= c_lat_m1;
                    end
`ifdef WRBUF_EN
                    if (w_go_post) begin
                        r_gnt       <= w_sel;
                        r_rr        <= ~w_sel;
                        r_buf_valid <= 1'b1;
                        r_buf_addr  <= w_sel_addr & c_blk_mask;
                        r_buf_data  <= w_sel_wdata;
                    end
                    if (w_go_drain) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_buf_addr;
                        mem_wdata <= r_buf_data;
                        r_cnt     <= c_lat_m1;
                    end
`endif
                end
                c_st_access: begin
                    if (r_cnt == 4'd0) begin
                        if (!mem_we) begin
                            if (r_gnt) begin
                                rdata1 <= mem_rdata;
                            end else begin
                                rdata0 <= mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`ifdef WRBUF_EN
                c_st_drain: begin
                    if (r_cnt == 4'd0) begin
                        r_buf_valid <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
